// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-client block RAM arbiter.
//   BRAM_ADDR_WIDTH / BRAM_DATA_WIDTH : RAM geometry (256 x 16).
//   READ_MODE / WRITE_MODE            : SB_RAM40_4K mode 0 (16-bit port).
//   arb_state_t                       : arbiter states, CLEAR (zero-fill) and RUN.
package bram_arb_pkg;
  localparam int BRAM_ADDR_WIDTH = 8;
  localparam int BRAM_DATA_WIDTH = 16;

  localparam logic [1:0] READ_MODE  = 2'd0;
  localparam logic [1:0] WRITE_MODE = 2'd0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;
endpackage

// File: rtl/bram_256x16.sv
// 256 x 16 simple dual-port RAM: one write port and one registered read port
// on a single clock.
//   clk               : RCLK and WCLK
//   waddr/wdata/we    : write port, all bits written (MASK tied to 0)
//   raddr/re/rdata    : read port, rdata updates at the edge where re=1
// A same-address write and read in one cycle returns the old contents.
// Macro BRAM_ARB_USE_SB_RAM selects the iCE40 SB_RAM40_4K primitive; otherwise
// a behavioural array with identical timing is used.
import bram_arb_pkg::*;

module bram_256x16 #(
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = BRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

`ifdef BRAM_ARB_USE_SB_RAM
  // Mode 0 uses the low 8 bits of the 11-bit address fields.
  SB_RAM40_4K #(
    .READ_MODE  (READ_MODE),
    .WRITE_MODE (WRITE_MODE)
  ) u_ram (
    .RDATA (rdata),
    .RADDR ({3'b000, raddr}),
    .RCLK  (clk),
    .RCLKE (re),
    .RE    (re),
    .WADDR ({3'b000, waddr}),
    .WCLK  (clk),
    .WCLKE (we),
    .WDATA (wdata),
    .WE    (we),
    .MASK  (16'h0000)
  );
`else
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    // Non-blocking read sees the pre-write contents on an address collision.
    if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 256 x 16 block RAM between clients A and B.
//   CLK, reset_n                      : clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata -> a_ack: client A request, accepted when a_ack=1
//   a_rvalid/a_rdata                  : client A read data, one cycle after ack
//   b_*                               : identical set for client B
//   clear_done                        : RAM usable
// Handshake: a client raises req with we/addr/wdata stable and holds them
// until ack; the transaction completes at the rising edge where ack=1.
// A read and a write from different clients are both granted in one cycle.
// Two reads or two writes conflict; prio_b picks the winner and toggles only
// after a conflict, so the loser wins the next one.
// Macro BRAM_ARB_CLEAR_EN: after reset, zero-fill all 256 words (CLEAR state)
// with clients locked out, then enter RUN. Without it the arbiter is always
// in RUN and clear_done is constant 1.
import bram_arb_pkg::*;

module bram_port_arbiter #(
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = BRAM_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  clear_done
);

  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clear_active;
  logic                  prio_b;
  logic                  conflict;
  logic                  a_rd, a_wr, b_rd, b_wr;
  logic                  a_pend, b_pend;
  logic [DATA_WIDTH-1:0] a_hold, b_hold;

  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

`ifdef BRAM_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clear_done_q;

  // Counter stops at its maximum; the last write is issued with clr_cnt='1.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CLEAR;
      clr_cnt      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == '1) begin
            state        <= ST_RUN;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign clr_addr   = clr_cnt;
  assign clear_done = clear_done_q;
`else
  assign state      = ST_RUN;
  assign clr_addr   = '0;
  assign clear_done = 1'b1;
`endif

  assign clear_active = (state == ST_CLEAR);

  // Grant: conflict only when both request the same port type.
  assign conflict = a_req && b_req && (a_we == b_we);
  assign a_ack    = (state == ST_RUN) && a_req && (!conflict || !prio_b);
  assign b_ack    = (state == ST_RUN) && b_req && (!conflict ||  prio_b);
  assign a_wr     = a_ack &&  a_we;
  assign a_rd     = a_ack && !a_we;
  assign b_wr     = b_ack &&  b_we;
  assign b_rd     = b_ack && !b_we;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    if (clear_active) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
    end else if (a_wr) begin
      ram_we    = 1'b1;
      ram_waddr = a_addr;
      ram_wdata = a_wdata;
    end else if (b_wr) begin
      ram_we    = 1'b1;
      ram_waddr = b_addr;
      ram_wdata = b_wdata;
    end
    if (a_rd) begin
      ram_re    = 1'b1;
      ram_raddr = a_addr;
    end else if (b_rd) begin
      ram_re    = 1'b1;
      ram_raddr = b_addr;
    end
  end

  // a_pend/b_pend mark whose read is sitting in the RAM output register;
  // the hold registers keep each client's rdata when it is not being served.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      prio_b <= 1'b0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      if ((state == ST_RUN) && conflict) prio_b <= !prio_b;
      a_pend <= a_rd;
      b_pend <= b_rd;
      if (a_pend) a_hold <= ram_rdata;
      if (b_pend) b_hold <= ram_rdata;
    end
  end

  assign a_rvalid = a_pend;
  assign b_rvalid = b_pend;
  assign a_rdata  = a_pend ? ram_rdata : a_hold;
  assign b_rdata  = b_pend ? ram_rdata : b_hold;

  bram_256x16 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (CLK),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .we    (ram_we),
    .raddr (ram_raddr),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter. Works with or without
// BRAM_ARB_CLEAR_EN; the clear-sweep scenarios are built only when it is set.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_bram_port_arbiter;

`ifdef BRAM_ARB_CLEAR_EN
  localparam logic EXP_CD_RESET = 1'b0;
`else
  localparam logic EXP_CD_RESET = 1'b1;
`endif

  logic        CLK;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid, clear_done;
  logic [15:0] a_rdata, b_rdata;

  int n_vec = 0;
  int n_err = 0;

  bram_port_arbiter dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_ack      (a_ack),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_ack      (b_ack),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .clear_done (clear_done)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = 8'h00; a_wdata = 16'h0000;
    b_req = 0; b_we = 0; b_addr = 8'h00; b_wdata = 16'h0000;
  endtask

  // Releases reset and, with the clear sweep built, measures its length and
  // checks that a request raised during the sweep is not acked.
  task automatic release_reset(input string tag);
    int cycles;
    reset_n = 1'b1;
`ifdef BRAM_ARB_CLEAR_EN
    cycles = 0;
    a_req = 1; a_we = 0; a_addr = 8'h45;
    while (!clear_done && cycles < 400) begin
      step();
      cycles++;
      if (cycles == 10) begin
        n_vec++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL %s_lockout: a_ack=%b want 0", tag, a_ack); end
        a_req = 0;
      end
    end
    n_vec++; if (cycles !== 256) begin n_err++; $display("FAIL %s_clear_len: %0d cycles want 256", tag, cycles); end
`else
    cycles = 0;
    #1;
    n_vec++; if (clear_done !== 1'b1) begin n_err++; $display("FAIL %s_clear_done: got %b want 1 (%0d)", tag, clear_done, cycles); end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;
    n_vec++; if (a_ack !== 1'b0)        begin n_err++; $display("FAIL rst_a_ack: got %b want 0", a_ack); end
    n_vec++; if (b_ack !== 1'b0)        begin n_err++; $display("FAIL rst_b_ack: got %b want 0", b_ack); end
    n_vec++; if (a_rvalid !== 1'b0)     begin n_err++; $display("FAIL rst_a_rvalid: got %b want 0", a_rvalid); end
    n_vec++; if (b_rvalid !== 1'b0)     begin n_err++; $display("FAIL rst_b_rvalid: got %b want 0", b_rvalid); end
    n_vec++; if (a_rdata !== 16'h0000)  begin n_err++; $display("FAIL rst_a_rdata: got %h want 0000", a_rdata); end
    n_vec++; if (b_rdata !== 16'h0000)  begin n_err++; $display("FAIL rst_b_rdata: got %h want 0000", b_rdata); end
    n_vec++; if (clear_done !== EXP_CD_RESET) begin n_err++; $display("FAIL rst_clear_done: got %b want %b", clear_done, EXP_CD_RESET); end
    release_reset("init");
`ifdef BRAM_ARB_CLEAR_EN
    // Cleared word reads back as zero.
    a_req = 1; a_we = 0; a_addr = 8'h45;
    #1;
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL clr_rd_ack: got %b want 1", a_ack); end
    step();
    a_req = 0;
    n_vec++; if (a_rvalid !== 1'b1)     begin n_err++; $display("FAIL clr_rd_rvalid: got %b want 1", a_rvalid); end
    n_vec++; if (a_rdata !== 16'h0000)  begin n_err++; $display("FAIL clr_rd_data: got %h want 0000", a_rdata); end
`endif
  endtask

  task automatic test_write_read_a();
    idle_inputs();
    a_req = 1; a_we = 1; a_addr = 8'h99; a_wdata = 16'ha50f;
    #1;
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL wr_a_ack: got %b want 1", a_ack); end
    n_vec++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL wr_b_ack: got %b want 0", b_ack); end
    step();
    n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 0", a_rvalid); end
    a_we = 0;
    #1;
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL rd_a_ack: got %b want 1", a_ack); end
    step();
    a_req = 0;
    n_vec++; if (a_rvalid !== 1'b1)    begin n_err++; $display("FAIL rd_a_rvalid: got %b want 1", a_rvalid); end
    n_vec++; if (a_rdata !== 16'ha50f) begin n_err++; $display("FAIL rd_a_rdata: got %h want a50f", a_rdata); end
    n_vec++; if (b_rvalid !== 1'b0)    begin n_err++; $display("FAIL rd_b_rvalid: got %b want 0", b_rvalid); end
    step();
    n_vec++; if (a_rvalid !== 1'b0)    begin n_err++; $display("FAIL rd_a_pulse: got %b want 0", a_rvalid); end
    n_vec++; if (a_rdata !== 16'ha50f) begin n_err++; $display("FAIL rd_a_hold: got %h want a50f", a_rdata); end
  endtask

  task automatic test_rd_wr_same_cycle();
    idle_inputs();
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 16'h0000;
    step();
    a_we = 0;
    b_req = 1; b_we = 1; b_addr = 8'h10; b_wdata = 16'h1234;
    #1;
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL rw_a_ack: got %b want 1", a_ack); end
    n_vec++; if (b_ack !== 1'b1) begin n_err++; $display("FAIL rw_b_ack: got %b want 1", b_ack); end
    step();
    b_req = 0;
    n_vec++; if (a_rvalid !== 1'b1)    begin n_err++; $display("FAIL rw_rvalid: got %b want 1", a_rvalid); end
    n_vec++; if (a_rdata !== 16'h0000) begin n_err++; $display("FAIL rw_old_data: got %h want 0000", a_rdata); end
    n_vec++; if (b_rvalid !== 1'b0)    begin n_err++; $display("FAIL rw_b_rvalid: got %b want 0", b_rvalid); end
    #1;
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL rw_reread_ack: got %b want 1", a_ack); end
    step();
    a_req = 0;
    n_vec++; if (a_rdata !== 16'h1234) begin n_err++; $display("FAIL rw_new_data: got %h want 1234", a_rdata); end
  endtask

  task automatic test_read_conflict();
    logic [3:0]  exp_a_win;
    logic [15:0] exp_a_data, exp_b_data;
    exp_a_win  = 4'b0101;   // bit i: A wins cycle i
    exp_a_data = 16'h2020;
    exp_b_data = 16'h2121;
    idle_inputs();
    a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 16'h2020;
    step();
    a_addr = 8'h21; a_wdata = 16'h2121;
    step();
    a_we = 0; a_addr = 8'h20;
    b_req = 1; b_we = 0; b_addr = 8'h21;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (a_ack !== exp_a_win[i])  begin n_err++; $display("FAIL rc_a_ack[%0d]: got %b want %b", i, a_ack, exp_a_win[i]); end
      n_vec++; if (b_ack !== !exp_a_win[i]) begin n_err++; $display("FAIL rc_b_ack[%0d]: got %b want %b", i, b_ack, !exp_a_win[i]); end
      step();
      if (exp_a_win[i]) begin
        n_vec++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin n_err++; $display("FAIL rc_rvalid[%0d]: a=%b b=%b want a=1 b=0", i, a_rvalid, b_rvalid); end
        n_vec++; if (a_rdata !== exp_a_data) begin n_err++; $display("FAIL rc_a_data[%0d]: got %h want %h", i, a_rdata, exp_a_data); end
      end else begin
        n_vec++; if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0) begin n_err++; $display("FAIL rc_rvalid[%0d]: a=%b b=%b want a=0 b=1", i, a_rvalid, b_rvalid); end
        n_vec++; if (b_rdata !== exp_b_data) begin n_err++; $display("FAIL rc_b_data[%0d]: got %h want %h", i, b_rdata, exp_b_data); end
      end
    end
    a_req = 0; b_req = 0;
  endtask

  // Write conflict (A wins, prio flips to B), then a read conflict B wins.
  task automatic test_write_conflict();
    idle_inputs();
    a_req = 1; a_we = 1; a_addr = 8'h30; a_wdata = 16'haaaa;
    b_req = 1; b_we = 1; b_addr = 8'h30; b_wdata = 16'hbbbb;
    #1;
    n_vec++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin n_err++; $display("FAIL wc_first: a=%b b=%b want a=1 b=0", a_ack, b_ack); end
    step();
    a_req = 0;
    #1;
    n_vec++; if (b_ack !== 1'b1) begin n_err++; $display("FAIL wc_loser_wait: b_ack=%b want 1", b_ack); end
    step();
    a_req = 1; a_we = 0;
    b_we = 0;
    #1;
    n_vec++; if (a_ack !== 1'b0 || b_ack !== 1'b1) begin n_err++; $display("FAIL wc_prio_b: a=%b b=%b want a=0 b=1", a_ack, b_ack); end
    step();
    b_req = 0;
    n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== 16'hbbbb) begin n_err++; $display("FAIL wc_b_read: v=%b d=%h want v=1 d=bbbb", b_rvalid, b_rdata); end
    #1;
    n_vec++; if (a_ack !== 1'b1) begin n_err++; $display("FAIL wc_a_wait: a_ack=%b want 1", a_ack); end
    step();
    a_req = 0;
    n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== 16'hbbbb) begin n_err++; $display("FAIL wc_a_read: v=%b d=%h want v=1 d=bbbb", a_rvalid, a_rdata); end
  endtask

  task automatic test_reset_run();
    idle_inputs();
    a_req = 1; a_we = 0; a_addr = 8'h99;
    step();
    a_req = 0;
    n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL rr_pending: got %b want 1", a_rvalid); end
    reset_n = 0;
    #1;
    n_vec++; if (a_rvalid !== 1'b0)       begin n_err++; $display("FAIL rr_rvalid_drop: got %b want 0", a_rvalid); end
    n_vec++; if (a_rdata !== 16'h0000)    begin n_err++; $display("FAIL rr_a_rdata: got %h want 0000", a_rdata); end
    n_vec++; if (b_rdata !== 16'h0000)    begin n_err++; $display("FAIL rr_b_rdata: got %h want 0000", b_rdata); end
    n_vec++; if (clear_done !== EXP_CD_RESET) begin n_err++; $display("FAIL rr_clear_done: got %b want %b", clear_done, EXP_CD_RESET); end
    step();
    release_reset("run_rst");
  endtask

`ifdef BRAM_ARB_CLEAR_EN
  task automatic test_reset_mid_clear();
    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;
    repeat (128) step();   // sweep now at address 8'h80
    n_vec++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL mc_busy: clear_done=%b want 0", clear_done); end
    reset_n = 0;
    #1;
    n_vec++; if (clear_done !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin n_err++; $display("FAIL mc_reset_vals: cd=%b a=%b b=%b want 0", clear_done, a_ack, b_ack); end
    step();
    release_reset("mid_clear");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read_a();
    test_rd_wr_same_cycle();
    test_read_conflict();
    test_write_conflict();
    test_reset_run();
`ifdef BRAM_ARB_CLEAR_EN
    test_reset_mid_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one iCE40 SB_RAM40_4K block RAM, configured 256×16, between two independent requesters, A and B. Each requester uses a req/ack handshake. The block drives the RAM's write port and read port each cycle and returns read data with a valid strobe. It sits between the user logic of an icestick design and the block RAM. It optionally zero-fills the RAM after reset.

## Interface
Parameters:
- ADDR_WIDTH, 8: word address width (256 words).
- DATA_WIDTH, 16: word width; the RAM runs in mode 0, 16-bit.

Ports:
- CLK  in  1  single clock; it also drives the RAM's RCLK and WCLK.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  client A request; held until a_ack.
- a_we  in  1  client A: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  client A word address.
- a_wdata  in  DATA_WIDTH  client A write data.
- a_ack  out  1  client A request accepted this cycle.
- a_rvalid  out  1  client A read data valid.
- a_rdata  out  DATA_WIDTH  client A read data.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: identical set for client B.
- clear_done  out  1  high once the RAM is usable.

## Operation
- States: CLEAR and RUN.
  - Reset enters CLEAR if BRAM_ARB_CLEAR_EN is defined, otherwise RUN.
  - CLEAR moves to RUN after the last clear write.
  - RUN is held until reset.
- RUN, per-cycle grant. The RAM has one read port and one write port.
  - One request only: it is granted.
  - One read and one write, from different clients: both are granted in the same cycle.
  - Two reads or two writes: conflict. The client with priority is granted; the other waits with req held.
- Priority flag prio_b:
  - Reset value 0, so A wins the first conflict.
  - Toggles only after a conflict cycle, so the loser wins the next conflict.
  - Non-conflict grants leave it unchanged.
- ack is combinational from the req signals, we and prio_b. It is forced to 0 outside RUN. The transaction completes at the rising edge where ack=1.
- A write is committed to the RAM at that edge. WE and WCLKE are asserted only while a write is granted.
- Read data: rvalid pulses one cycle after the read's ack. rdata is the RAM RDATA routed to the granted client. The rdata output of the non-granted client holds its last value.
- Same-address write and read in one cycle: the read returns the old contents. This is the native SB_RAM40_4K behaviour, with no bypass.
- The MASK input is tied to 0 (all bits written).
- CLEAR:
  - A counter from 0 to 2^ADDR_WIDTH−1 writes 16'h0000 at one address per cycle.
  - No acks are given; the reads stay idle.
  - clear_done goes high in the cycle after the final write.

## Timing
- Reset values: a_ack=0, b_ack=0, a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0, prio_b=0, clear counter=0.
  - clear_done=0 with BRAM_ARB_CLEAR_EN defined, 1 without it.
- Write latency: 0 cycles to acceptance. Data is visible to a read acked at the next edge or later.
- Read latency: ack at edge N, rvalid and rdata in the cycle following N, i.e. one cycle.
- Throughput: one read plus one write per cycle at most.
- A losing client waits at most 1 cycle while both clients request continuously.
- Reset asserted mid-clear aborts the sweep; the next release restarts it at address 0.
- Reset asserted during RUN drops any pending rvalid. Asynchronous assertion; release is taken at the clock edge.
- Address wrap: not applicable. Addresses are exactly ADDR_WIDTH bits, and the clear counter stops at its maximum without wrapping.

## Configuration
- Macro: BRAM_ARB_CLEAR_EN.
- Defined:
  - The CLEAR state is built, taking 2^ADDR_WIDTH cycles (256 with defaults).
  - Clients are locked out until clear_done=1.
  - The RAM INIT contents are irrelevant.
- Not defined:
  - No CLEAR state and no counter.
  - clear_done is constantly 1.
  - The RAM starts with its INIT contents, all zero.

## Structure
- Shared package bram_arb_pkg:
  - BRAM_ADDR_WIDTH=8 and BRAM_DATA_WIDTH=16.
  - RAM mode constants READ_MODE=0 and WRITE_MODE=0.
  - State encodings ST_CLEAR and ST_RUN.
- Sub-module bram_256x16:
  - Wraps the SB_RAM40_4K instance and ties MASK and the mode parameters.
  - Exposes waddr/wdata/we and raddr/re/rdata.
  - Lets the arbiter be simulated against a behavioural model.

## Test plan
- Reset, then wait, with BRAM_ARB_CLEAR_EN defined:
  - clear_done rises exactly 256 cycles after reset release.
  - A read of address 8'h45 returns 16'h0000.
- A writes 16'ha50f at 8'h99, then A reads 8'h99:
  - a_ack on both requests.
  - a_rvalid one cycle after the read ack, with a_rdata=16'ha50f.
- A reads 8'h10 while B writes 16'h1234 at 8'h10 in the same cycle:
  - Both acked.
  - a_rdata is the old value 16'h0000.
  - A read of 8'h10 on the next cycle returns 16'h1234.
- A and B both hold read requests for 4 cycles:
  - Acks alternate A, B, A, B.
  - Each rvalid lands on the correct client with the correct data.
- reset_n pulsed low at clear address 8'h80:
  - All outputs return to reset values immediately.
  - The clear restarts, and clear_done rises 256 cycles after release.
